// File: rtl/alu_issue.sv
// alu_issue: issue/response sequencer for a multi-cycle ALU.
// Accepts one command at a time, drives the operands to the ALU and strobes
// the sequential units for shift and multiply ops. It then waits out the
// op's latency, captures the result and holds it until the consumer takes it.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_op/cmd_a/cmd_b payload
//   alu_op/alu_a/alu_b          registered command driven to the ALU
//   alu_inp                     one-cycle start strobe (lshift/rshift/mul only)
//   alu_y/alu_y_ext/alu_flg     ALU result low/high halves and flag
//   rsp_valid/rsp_ready         response handshake
//   rsp_lo/rsp_hi/rsp_flg/rsp_op captured response
//   busy                        high whenever the FSM is not in IDLE
module alu_issue #(
  parameter int N       = 8,
  parameter int SHF_LAT = 1,
  parameter int MUL_LAT = N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_inp,
  input  logic [N-1:0] alu_y,
  input  logic [N-1:0] alu_y_ext,
  input  logic         alu_flg,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_lo,
  output logic [N-1:0] rsp_hi,
  output logic         rsp_flg,
  output logic [2:0]   rsp_op,
  output logic         busy
);

  // Counter holds at most max(SHF_LAT, MUL_LAT)-1.
  localparam int MAX_LAT = (SHF_LAT > MUL_LAT) ? SHF_LAT : MUL_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LSH = 3'b101;
  localparam logic [2:0] OP_RSH = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_init;
  logic          seq_op;
  logic          accept;

  assign seq_op = (alu_op == OP_LSH) || (alu_op == OP_RSH) || (alu_op == OP_MUL);
  assign accept = (state == IDLE) && cmd_valid;

  // Latency minus one: the ISSUE->WAIT edge already accounts for one cycle.
  always_comb begin
    cnt_init = '0;
    case (alu_op)
      OP_MUL:         cnt_init = CW'(MUL_LAT - 1);
      OP_LSH, OP_RSH: cnt_init = CW'(SHF_LAT - 1);
      default:        cnt_init = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    alu_inp   = 1'b0;
    case (state)
      IDLE:    begin cmd_ready = 1'b1; busy = 1'b0; end
      ISSUE:   alu_inp   = seq_op;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command registers: loaded only on accept, so they stay put for the
  // whole operation and the ALU sees stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (accept) begin
      alu_op <= cmd_op;
      alu_a  <= cmd_a;
      alu_b  <= cmd_b;
    end
  end

  // Latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt <= '0;
    else if (state == ISSUE)              cnt <= cnt_init;
    else if (state == WAIT && cnt != '0)  cnt <= cnt - 1'b1;
  end

  // Response capture; the registers keep their value after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_lo  <= '0;
      rsp_hi  <= '0;
      rsp_flg <= 1'b0;
      rsp_op  <= '0;
    end else if (state == WAIT && cnt == '0) begin
      rsp_lo  <= alu_y;
      rsp_hi  <= (alu_op == OP_MUL) ? alu_y_ext : '0;
      rsp_flg <= (alu_op == OP_ADD || alu_op == OP_SUB) ? alu_flg : 1'b0;
      rsp_op  <= alu_op;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a behavioural ALU.
// The ALU model drives junk on unused outputs (alu_y_ext, alu_flg) and on
// sequential results before their latency has elapsed, so wrong capture
// timing or missing output gating shows up as a wrong response value.
module tb_alu_issue;
  localparam int N       = 8;
  localparam int SHF_LAT = 1;
  localparam int MUL_LAT = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_a, cmd_b;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_a, alu_b;
  logic         alu_inp;
  logic [N-1:0] alu_y, alu_y_ext;
  logic         alu_flg;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_lo, rsp_hi;
  logic         rsp_flg;
  logic [2:0]   rsp_op;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_issue #(.N(N), .SHF_LAT(SHF_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_inp(alu_inp),
    .alu_y(alu_y), .alu_y_ext(alu_y_ext), .alu_flg(alu_flg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_flg(rsp_flg), .rsp_op(rsp_op),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ops 000-100 combinational, shifts/mul latched on the
  // strobe and valid only once their latency has run out.
  logic [15:0] seq_res;
  logic        pend;
  int          rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; rem <= 0; seq_res <= '0;
    end else if (alu_inp) begin
      pend <= 1'b1;
      rem  <= (alu_op == 3'b111) ? MUL_LAT - 1 : SHF_LAT - 1;
      case (alu_op)
        3'b101:  seq_res <= {8'hA5, alu_a << alu_b};
        3'b110:  seq_res <= {8'hA5, alu_a >> alu_b};
        default: seq_res <= alu_a * alu_b;
      endcase
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end

  always_comb begin
    alu_y = '0; alu_y_ext = 8'hA5; alu_flg = 1'b1;
    case (alu_op)
      3'b000: {alu_flg, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin alu_y = alu_a - alu_b; alu_flg = (alu_a < alu_b); end
      3'b010: alu_y = alu_a & alu_b;
      3'b011: alu_y = alu_a | alu_b;
      3'b100: alu_y = ~alu_a;
      default: begin
        if (pend && rem == 0) {alu_y_ext, alu_y} = seq_res;
        else begin alu_y = 8'hEE; alu_y_ext = 8'hEE; end
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command with rsp_ready high; checks latency, strobe count and result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int lat, input logic [7:0] lo,
                        input logic [7:0] hi, input logic flg);
    int cyc, strobes;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    chk({tag, "_rdy"}, 32'(cmd_ready), 1);
    strobes = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      strobes += int'(alu_inp);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 2 + lat);
    chk({tag, "_inp"}, strobes, (op >= 3'b101) ? 1 : 0);
    chk({tag, "_lo"},  32'(rsp_lo),  32'(lo));
    chk({tag, "_hi"},  32'(rsp_hi),  32'(hi));
    chk({tag, "_flg"}, 32'(rsp_flg), 32'(flg));
    chk({tag, "_op"},  32'(rsp_op),  32'(op));
    @(negedge clk);
    chk({tag, "_drop"}, 32'(rsp_valid), 0);
    chk({tag, "_hold"}, 32'(rsp_lo), 32'(lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nrsp, rdy_between, seen;
    logic [2:0] ops [2];
    logic [7:0] los [2];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_inp",   32'(alu_inp), 0);
    chk("rst_aluop", 32'(alu_op), 0);
    chk("rst_alua",  32'(alu_a), 0);
    chk("rst_alub",  32'(alu_b), 0);
    chk("rst_rsp",   {8'h0, rsp_lo, rsp_hi, 4'h0, rsp_flg, rsp_op}, 0);
    rst_n = 1'b1;

    run_op("add",  3'b000, 8'd200, 8'd100, 1,       8'd44,  8'h00, 1'b1);
    run_op("mul",  3'b111, 8'd15,  8'd17,  MUL_LAT, 8'hFF,  8'h00, 1'b0);
    run_op("mul2", 3'b111, 8'd200, 8'd100, MUL_LAT, 8'h20,  8'h4E, 1'b0);
    run_op("sub",  3'b001, 8'd5,   8'd9,   1,       8'hFC,  8'h00, 1'b1);
    run_op("not",  3'b100, 8'h5A,  8'h00,  1,       8'hA5,  8'h00, 1'b0);
    run_op("lsh",  3'b101, 8'h81,  8'd1,   SHF_LAT, 8'h02,  8'h00, 1'b0);

    // Backpressure: response must hold and a competing command must wait.
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 8'hF0; cmd_b = 8'h3C;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
    chk("bp_lat", cyc, 3);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'd1; cmd_b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_lo",    32'(rsp_lo), 32'h30);
      chk("bp_ready", 32'(cmd_ready), 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop",  32'(rsp_valid), 0);
    chk("bp_rspop", 32'(rsp_op), 32'(3'b010));
    chk("bp_aluop", 32'(alu_op), 32'(3'b010));

    // Back-to-back with cmd_valid and rsp_ready held high.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'h0F; cmd_b = 8'h30;
    @(negedge clk);
    cmd_op = 3'b110; cmd_a = 8'h80; cmd_b = 8'd3;
    nrsp = 0; rdy_between = 0;
    ops[0] = '0; ops[1] = '0; los[0] = '0; los[1] = '0;
    for (cyc = 0; cyc < 40 && nrsp < 2; cyc++) begin
      if (rsp_valid) begin
        ops[nrsp] = rsp_op; los[nrsp] = rsp_lo; nrsp++;
      end else if (nrsp == 1 && cmd_ready) begin
        rdy_between++;
      end
      if (nrsp < 2) @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_nrsp", nrsp, 2);
    chk("b2b_op0",  32'(ops[0]), 32'(3'b011));
    chk("b2b_lo0",  32'(los[0]), 32'h3F);
    chk("b2b_op1",  32'(ops[1]), 32'(3'b110));
    chk("b2b_lo1",  32'(los[1]), 32'h10);
    chk("b2b_gap",  rdy_between, 1);
    repeat (2) @(negedge clk);
    chk("b2b_idle", 32'(busy), 0);

    // Reset while a multiply is waiting: no response may ever appear.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 8'd3; cmd_b = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rbusy",  32'(busy), 0);
    chk("mid_rvalid", 32'(rsp_valid), 0);
    chk("mid_rready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_norsp", seen, 0);
    run_op("post", 3'b000, 8'd1, 8'd1, 1, 8'd2, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
